// File: rtl/sap_ctrl_pkg.sv
// Shared definitions for the SAP microsequencer: control-word bit indices,
// opcode encodings and a one-hot helper used to compose micro-steps.
package sap_ctrl_pkg;

  localparam int CTRL_W_DEFAULT = 16;
  localparam int FETCH_STEPS    = 3;

  localparam int SIG_ADDER_EN  = 0;
  localparam int SIG_ADDER_SUB = 1;
  localparam int SIG_B_LOAD    = 2;
  localparam int SIG_A_EN      = 3;
  localparam int SIG_A_LOAD    = 4;
  localparam int SIG_IR_EN     = 5;
  localparam int SIG_IR_LOAD   = 6;
  localparam int SIG_MEM_EN    = 7;
  localparam int SIG_MEM_LOAD  = 8;
  localparam int SIG_PC_EN     = 9;
  localparam int SIG_PC_INC    = 10;
  localparam int SIG_HLT       = 11;
  localparam int SIG_OUT_LOAD  = 12;
  localparam int SIG_PC_LOAD   = 13;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  function automatic logic [CTRL_W_DEFAULT-1:0] sig(input int idx);
    sig = 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/sap_microcode_rom.sv
// Combinational microcode: maps (stage, opcode) to the raw control word and
// a flag marking the instruction's final live step.
module sap_microcode_rom
  import sap_ctrl_pkg::*;
#(
  parameter int OP_W       = 4,
  parameter int CTRL_W     = 16,
  parameter int MAX_STAGES = 6,
  parameter int STAGE_W    = 3
) (
  input  logic [STAGE_W-1:0] stage,
  input  logic [OP_W-1:0]    opcode,
  output logic [CTRL_W-1:0]  ctrl_raw,
  output logic               last
);

  logic [CTRL_W_DEFAULT-1:0] word;
  logic                      dec_last;

  // Fetch steps are opcode-independent; execute steps decode the live opcode.
  always_comb begin
    word     = '0;
    dec_last = 1'b0;
    if (stage < STAGE_W'(FETCH_STEPS)) begin
      case (stage)
        STAGE_W'(0): word = sig(SIG_PC_EN) | sig(SIG_MEM_LOAD);
        STAGE_W'(1): word = sig(SIG_PC_INC);
        STAGE_W'(2): word = sig(SIG_MEM_EN) | sig(SIG_IR_LOAD);
        default:     word = '0;
      endcase
    end else begin
      case (opcode)
        OP_W'(OP_LDA): begin
          case (stage)
            STAGE_W'(3): word = sig(SIG_IR_EN) | sig(SIG_MEM_LOAD);
            STAGE_W'(4): begin
              word     = sig(SIG_MEM_EN) | sig(SIG_A_LOAD);
              dec_last = 1'b1;
            end
            default: dec_last = 1'b1;
          endcase
        end
        OP_W'(OP_ADD), OP_W'(OP_SUB): begin
          case (stage)
            STAGE_W'(3): word = sig(SIG_IR_EN) | sig(SIG_MEM_LOAD);
            STAGE_W'(4): word = sig(SIG_MEM_EN) | sig(SIG_B_LOAD);
            STAGE_W'(5): begin
              word     = sig(SIG_ADDER_EN) | sig(SIG_A_LOAD)
                       | ((opcode == OP_W'(OP_SUB)) ? sig(SIG_ADDER_SUB) : 16'h0000);
              dec_last = 1'b1;
            end
            default: dec_last = 1'b1;
          endcase
        end
        OP_W'(OP_JMP): begin
          word     = (stage == STAGE_W'(3)) ? (sig(SIG_IR_EN) | sig(SIG_PC_LOAD)) : 16'h0000;
          dec_last = 1'b1;
        end
        OP_W'(OP_OUT): begin
          word     = (stage == STAGE_W'(3)) ? (sig(SIG_A_EN) | sig(SIG_OUT_LOAD)) : 16'h0000;
          dec_last = 1'b1;
        end
        OP_W'(OP_HLT): begin
          word     = (stage == STAGE_W'(3)) ? sig(SIG_HLT) : 16'h0000;
          dec_last = 1'b1;
        end
        default: begin
          word     = '0;
          dec_last = 1'b1;
        end
      endcase
    end
  end

  // The final stage always terminates the instruction so the counter cannot run away.
  assign last     = dec_last | (stage >= STAGE_W'(MAX_STAGES - 1));
  assign ctrl_raw = CTRL_W'(word);

endmodule

// File: rtl/sap_microsequencer.sv
// SAP microsequencer top: T-state counter, sticky halt, advance qualification
// for free-run / single-step clocking, and gated control-word output.
module sap_microsequencer
  import sap_ctrl_pkg::*;
#(
  parameter int OP_W       = 4,
  parameter int CTRL_W     = 16,
  parameter int MAX_STAGES = 6,
  parameter int STAGE_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic               run,
  input  logic               step,
  output logic [CTRL_W-1:0]  ctrl,
  output logic [STAGE_W-1:0] stage,
  output logic               instr_done,
  output logic               halted
);

  logic [CTRL_W-1:0] ctrl_raw;
  logic              last;
  logic              adv;

  sap_microcode_rom #(
    .OP_W       (OP_W),
    .CTRL_W     (CTRL_W),
    .MAX_STAGES (MAX_STAGES),
    .STAGE_W    (STAGE_W)
  ) u_rom (
    .stage    (stage),
    .opcode   (opcode),
    .ctrl_raw (ctrl_raw),
    .last     (last)
  );

  assign adv        = ~halted & (run | step);
  assign instr_done = adv & last;

  // Stage counter and halt latch; only an advancing cycle moves either.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage  <= '0;
      halted <= 1'b0;
    end else if (adv) begin
      stage  <= last ? '0 : stage + STAGE_W'(1);
      halted <= ctrl_raw[SIG_HLT];
    end
  end

  // While halted only HLT is asserted; otherwise the word passes only on advance.
  always_comb begin
    ctrl = '0;
    if (halted) begin
      ctrl[SIG_HLT] = 1'b1;
    end else if (adv) begin
      ctrl = ctrl_raw;
    end else begin
      ctrl = '0;
    end
  end

endmodule
